// File: rtl/alu_writeback.sv
// Writeback stage behind the 8-bit ALU: queues results, drains one per cycle into the
// register file, keeps Z/N/C/V, and forwards queued writes to the two operand read ports.
module alu_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_arith,
  input  logic              wb_cout,
  input  logic              wb_ovf,
  input  logic              drain_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              flag_v,
  output logic [ADDR_W:0]   pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = ADDR_W + 1;
  localparam int NREG  = 2**ADDR_W;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              arith;
    logic              cout;
    logic              ovf;
  } entry_t;

  entry_t            r_q [DEPTH];
  logic [DATA_W-1:0] r_regs [NREG];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_flag_z, r_flag_n, r_flag_c, r_flag_v;

  logic              w_full, w_empty, w_push, w_pop;
  entry_t            w_in, w_head;
  logic [PTR_W-1:0]  w_slot [DEPTH];
  logic [DATA_W-1:0] w_operand_a, w_operand_b;

  // Full/empty come from the count so a wrapped pointer pair is never ambiguous.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = wb_valid & ~w_full;
  assign w_pop   = drain_en & ~w_empty;
  assign w_in    = '{we: wb_we, addr: wb_addr, data: wb_data,
                     arith: wb_arith, cout: wb_cout, ovf: wb_ovf};
  assign w_head  = r_q[r_rd_ptr];

  // NOTE: queue payload is left unreset; only slots covered by r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr_ptr] <= w_in;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_v <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_head.we) r_regs[w_head.addr] <= w_head.data;
        r_flag_z <= (w_head.data == '0);
        r_flag_n <= w_head.data[DATA_W-1];
        if (w_head.arith) begin
          r_flag_c <= w_head.cout;
          r_flag_v <= w_head.ovf;
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) w_slot[i] = r_rd_ptr + PTR_W'(i);
  end

  // Walk oldest to newest so the youngest matching write wins.
  always_comb begin
    // NOTE: defaults first so no path leaves the outputs unassigned (no latch).
    w_operand_a = r_regs[rd_addr_a];
    w_operand_b = r_regs[rd_addr_b];
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < r_count && r_q[w_slot[i]].we) begin
        if (r_q[w_slot[i]].addr == rd_addr_a) w_operand_a = r_q[w_slot[i]].data;
        if (r_q[w_slot[i]].addr == rd_addr_b) w_operand_b = r_q[w_slot[i]].data;
      end
    end
  end

  assign operand_a = w_operand_a;
  assign operand_b = w_operand_b;
  assign wb_ready  = ~w_full;
  assign pending   = r_count;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;
  assign flag_c    = r_flag_c;
  assign flag_v    = r_flag_v;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: directed vector table for the corner cases, then random
// traffic compared every cycle against a queue-based reference model.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst, wb_valid, wb_ready, wb_we, wb_arith, wb_cout, wb_ovf, drain_en;
  logic [1:0] wb_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wb_data, operand_a, operand_b;
  logic       flag_z, flag_n, flag_c, flag_v;
  logic [2:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  alu_writeback #(.DATA_W(8), .ADDR_W(2), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_arith(wb_arith), .wb_cout(wb_cout),
    .wb_ovf(wb_ovf), .drain_en(drain_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .operand_a(operand_a), .operand_b(operand_b), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  typedef struct {
    logic       rst, valid, we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       arith, cout, ovf, drain;
    logic [1:0] ra, rb;
    logic [7:0] ea, eb;
    logic [2:0] ep;
    logic       er;
    logic [3:0] ef;  // {Z,N,C,V}
  } vec_t;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic       arith, cout, ovf;
  } ent_t;

  // Reference model: a plain queue of pending writes plus the architectural state.
  ent_t       mq[$];
  logic [7:0] mregs [4];
  logic       mz, mn, mc, mv;

  function automatic logic [7:0] model_read(input logic [1:0] a);
    logic [7:0] r = mregs[a];
    foreach (mq[i]) if (mq[i].we && mq[i].addr == a) r = mq[i].data;
    return r;
  endfunction

  task automatic model_step(input vec_t v);
    bit   can_push, do_pop;
    ent_t e;
    if (v.rst) begin
      mq.delete();
      for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
      {mz, mn, mc, mv} = 4'b0000;
      return;
    end
    can_push = mq.size() < 2;
    do_pop   = v.drain && mq.size() > 0;
    if (do_pop) begin
      e = mq.pop_front();
      if (e.we) mregs[e.addr] = e.data;
      mz = (e.data == 8'h00);
      mn = e.data[7];
      if (e.arith) begin
        mc = e.cout;
        mv = e.ovf;
      end
    end
    if (v.valid && can_push) mq.push_back('{v.we, v.addr, v.data, v.arith, v.cout, v.ovf});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, vl, we, input logic [1:0] ad, input logic [7:0] d,
                              input logic ar, co, ov, dr, input logic [1:0] ra, rb,
                              input logic [7:0] ea, eb, input logic [2:0] ep,
                              input logic er, input logic [3:0] ef);
    vec_t v;
    v.rst = r; v.valid = vl; v.we = we; v.addr = ad; v.data = d;
    v.arith = ar; v.cout = co; v.ovf = ov; v.drain = dr; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb; v.ep = ep; v.er = er; v.ef = ef;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, then compare on the falling edge.
  task automatic apply(input vec_t v, input bit directed, input string tag);
    rst = v.rst; wb_valid = v.valid; wb_we = v.we; wb_addr = v.addr; wb_data = v.data;
    wb_arith = v.arith; wb_cout = v.cout; wb_ovf = v.ovf; drain_en = v.drain;
    rd_addr_a = v.ra; rd_addr_b = v.rb;
    @(posedge clk);
    model_step(v);
    @(negedge clk);
    if (directed) begin
      check({tag, "_opa"},   32'(operand_a), 32'(v.ea));
      check({tag, "_opb"},   32'(operand_b), 32'(v.eb));
      check({tag, "_pend"},  32'(pending),   32'(v.ep));
      check({tag, "_ready"}, 32'(wb_ready),  32'(v.er));
      check({tag, "_flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(v.ef));
    end else begin
      check({tag, "_opa"},   32'(operand_a), 32'(model_read(v.ra)));
      check({tag, "_opb"},   32'(operand_b), 32'(model_read(v.rb)));
      check({tag, "_pend"},  32'(pending),   32'(mq.size()));
      check({tag, "_ready"}, 32'(wb_ready),  32'(mq.size() < 2));
      check({tag, "_flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'({mz, mn, mc, mv}));
    end
  endtask

  vec_t tbl[$];

  initial begin
    @(negedge clk);
    //                  rst vl we ad  data  ar co ov dr ra rb   ea     eb     ep er ef
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 4'b0000));
    // push reg1=05 with drain on, retire next edge
    tbl.push_back(mk(0, 1, 1, 1, 8'h05, 0, 0, 0, 1, 1, 1, 8'h05, 8'h05, 1, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h05, 8'h00, 0, 1, 4'b0000));
    // forwarded 80 while held in the queue; N only moves on drain
    tbl.push_back(mk(0, 1, 1, 2, 8'h80, 0, 0, 0, 0, 2, 1, 8'h80, 8'h05, 1, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 2, 2, 8'h80, 8'h80, 1, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 2, 0, 8'h80, 8'h00, 0, 1, 4'b0100));
    // fill, blocked third push, in-order drain
    tbl.push_back(mk(0, 1, 1, 0, 8'h11, 0, 0, 0, 0, 0, 3, 8'h11, 8'h00, 1, 1, 4'b0100));
    tbl.push_back(mk(0, 1, 1, 3, 8'h33, 0, 0, 0, 0, 0, 3, 8'h11, 8'h33, 2, 0, 4'b0100));
    tbl.push_back(mk(0, 1, 1, 0, 8'h99, 0, 0, 0, 0, 0, 3, 8'h11, 8'h33, 2, 0, 4'b0100));
    tbl.push_back(mk(0, 1, 1, 0, 8'h99, 0, 0, 0, 1, 0, 3, 8'h11, 8'h33, 1, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 3, 8'h11, 8'h33, 0, 1, 4'b0000));
    // flag-only arith entry, then a non-arith FF holding C/V
    tbl.push_back(mk(0, 1, 0, 1, 8'h00, 1, 1, 1, 0, 1, 1, 8'h05, 8'h05, 1, 1, 4'b0000));
    tbl.push_back(mk(0, 1, 0, 0, 8'hFF, 0, 0, 0, 1, 0, 1, 8'h11, 8'h05, 1, 1, 4'b1011));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h05, 8'h11, 0, 1, 4'b0111));
    // two writes to reg3: newest forwarded
    tbl.push_back(mk(0, 1, 1, 3, 8'h11, 0, 0, 0, 0, 3, 3, 8'h11, 8'h11, 1, 1, 4'b0111));
    tbl.push_back(mk(0, 1, 1, 3, 8'h22, 0, 0, 0, 0, 0, 3, 8'h11, 8'h22, 2, 0, 4'b0111));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 3, 3, 8'h22, 8'h22, 1, 1, 4'b0011));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 3, 2, 8'h22, 8'h80, 0, 1, 4'b0011));
    // reset with two entries queued discards them
    tbl.push_back(mk(0, 1, 1, 1, 8'hAA, 0, 0, 0, 0, 1, 1, 8'hAA, 8'hAA, 1, 1, 4'b0011));
    tbl.push_back(mk(0, 1, 1, 2, 8'hBB, 0, 0, 0, 0, 1, 2, 8'hAA, 8'hBB, 2, 0, 4'b0011));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 2, 8'h00, 8'h00, 0, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 2, 8'h00, 8'h00, 0, 1, 4'b0000));
    tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 3, 0, 8'h00, 8'h00, 0, 1, 4'b0000));

    foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

    for (int c = 0; c < 3000; c++) begin
      vec_t v;
      logic [7:0] d;
      case ($urandom_range(0, 5))
        0:       d = 8'h00;
        1:       d = 8'h80;
        2:       d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      v = mk($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
             2'($urandom), d, 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 9) < 5, 2'($urandom), 2'($urandom),
             8'h00, 8'h00, 3'd0, 1'b0, 4'b0000);
      apply(v, 1'b0, $sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
